// File: rtl/ak4619_codec_target.sv
// Codec-side endpoint of the 4-slot, 32-bit-per-slot TDM link mastered by the AK4619 driver.
// Samples lrck/sdin on bick rise, drives sdout on bick fall, all in the clk domain.
module ak4619_codec_target #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         bick,
  input  logic         lrck,
  input  logic         sdin,
  output logic         sdout,
  output logic [W-1:0] sample_out0,
  output logic [W-1:0] sample_out1,
  output logic [W-1:0] sample_out2,
  output logic [W-1:0] sample_out3,
  output logic         sample_strobe,
  input  logic [W-1:0] sample_in0,
  input  logic [W-1:0] sample_in1,
  input  logic [W-1:0] sample_in2,
  input  logic [W-1:0] sample_in3,
  output logic         locked,
  output logic         frame_err
);

  localparam logic [5:0] WLim   = 6'(W);
  localparam logic [6:0] LastRx = 7'(96 + W - 1);

  logic [1:0]   bick_sync_q, lrck_sync_q, sdin_sync_q;
  logic         bick_dly_q, lrck_prev_q;
  logic [6:0]   cnt_q;
  logic [W-1:0] shift_q;
  logic [W-1:0] stage0_q, stage1_q, stage2_q;
  logic [W-1:0] tx_q [4];

  logic         rise, fall, frame_start, rx_en, rx_bit, rx_last, tx_latch;
  logic [6:0]   idx, nxt;
  logic [W-1:0] shift_d, tx_word, tx_shift;

  always_comb begin
    rise        = bick_sync_q[1] & ~bick_dly_q;
    fall        = ~bick_sync_q[1] & bick_dly_q;
    frame_start = ~lrck_sync_q[1] & lrck_prev_q;
    // Index of the bit being sampled on this rise.
    idx         = frame_start ? 7'd0 : cnt_q + 7'd1;
    rx_en       = locked | frame_start;
    rx_bit      = ({1'b0, idx[4:0]} < WLim);
    rx_last     = ({1'b0, idx[4:0]} == WLim - 6'd1);
    shift_d     = {shift_q[W-2:0], sdin_sync_q[1]};
    nxt         = cnt_q + 7'd1;
    tx_latch    = (nxt == 7'd0);
    // A frame boundary fall transmits slot 0 straight from the inputs being latched.
    tx_word     = tx_latch ? sample_in0 : tx_q[nxt[6:5]];
    tx_shift    = tx_word << nxt[4:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bick_sync_q   <= '0;
      lrck_sync_q   <= '0;
      sdin_sync_q   <= '0;
      bick_dly_q    <= 1'b0;
      lrck_prev_q   <= 1'b0;
      cnt_q         <= '0;
      shift_q       <= '0;
      stage0_q      <= '0;
      stage1_q      <= '0;
      stage2_q      <= '0;
      for (int i = 0; i < 4; i++) tx_q[i] <= '0;
      sdout         <= 1'b0;
      sample_out0   <= '0;
      sample_out1   <= '0;
      sample_out2   <= '0;
      sample_out3   <= '0;
      sample_strobe <= 1'b0;
      locked        <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      bick_sync_q   <= {bick_sync_q[0], bick};
      lrck_sync_q   <= {lrck_sync_q[0], lrck};
      sdin_sync_q   <= {sdin_sync_q[0], sdin};
      bick_dly_q    <= bick_sync_q[1];
      sample_strobe <= 1'b0;
      frame_err     <= 1'b0;

      if (rise) begin
        lrck_prev_q <= lrck_sync_q[1];
        cnt_q       <= idx;
        if (frame_start) begin
          locked <= 1'b1;
          if (locked && cnt_q != 7'd127) frame_err <= 1'b1;
        end
        if (rx_en && rx_bit) begin
          shift_q <= shift_d;
          if (rx_last) begin
            unique case (idx[6:5])
              2'd0: stage0_q <= shift_d;
              2'd1: stage1_q <= shift_d;
              2'd2: stage2_q <= shift_d;
              default: ;
            endcase
          end
          // A realigned frame restarts at 0, so only complete frames reach this point.
          if (idx == LastRx) begin
            sample_out0   <= stage0_q;
            sample_out1   <= stage1_q;
            sample_out2   <= stage2_q;
            sample_out3   <= shift_d;
            sample_strobe <= 1'b1;
          end
        end
      end

      if (fall) begin
        if (locked) begin
          if (tx_latch) begin
            tx_q[0] <= sample_in0;
            tx_q[1] <= sample_in1;
            tx_q[2] <= sample_in2;
            tx_q[3] <= sample_in3;
          end
          sdout <= ({1'b0, nxt[4:0]} < WLim) ? tx_shift[W-1] : 1'b0;
        end else begin
          sdout <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ak4619_codec_target.sv
// Directed bench: a model TDM master drives bick/lrck/sdin at 12 clk per BICK period
// and decodes sdout at each BICK rise.
module tb_ak4619_codec_target;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bick = 1'b1;
  logic        lrck = 1'b1;
  logic        sdin = 1'b0;
  logic        sdout;
  logic [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
  logic        sample_strobe;
  logic [15:0] sample_in0, sample_in1, sample_in2, sample_in3;
  logic        locked;
  logic        frame_err;

  ak4619_codec_target #(.W(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bick          (bick),
    .lrck          (lrck),
    .sdin          (sdin),
    .sdout         (sdout),
    .sample_out0   (sample_out0),
    .sample_out1   (sample_out1),
    .sample_out2   (sample_out2),
    .sample_out3   (sample_out3),
    .sample_strobe (sample_strobe),
    .sample_in0    (sample_in0),
    .sample_in1    (sample_in1),
    .sample_in2    (sample_in2),
    .sample_in3    (sample_in3),
    .locked        (locked),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int errs = 0;
  int dbl = 0;
  int padbad = 0;
  logic prev_strobe = 1'b0;

  logic [15:0] m_tx [4];
  logic [15:0] m_rx [4];
  logic        pad = 1'b0;

  always @(negedge clk) begin
    if (sample_strobe) begin
      strobes++;
      if (prev_strobe) dbl++;
    end
    if (frame_err) errs++;
    prev_strobe = sample_strobe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic lr, input logic d, output logic so);
    bick = 1'b0;
    lrck = lr;
    sdin = d;
    repeat (6) @(negedge clk);
    bick = 1'b1;
    so = sdout;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_range(input int first, input int last);
    logic so;
    for (int b = first; b <= last; b++) begin
      int slot = b / 32;
      int pos  = b % 32;
      logic d  = (pos < 16) ? m_tx[slot][15-pos] : pad;
      send_bit(b >= 64, d, so);
      if (pos < 16) m_rx[slot][15-pos] = so;
      else if (so !== 1'b0) padbad++;
    end
  endtask

  task automatic set_tx(input logic [15:0] a, b, c, d);
    m_tx[0] = a; m_tx[1] = b; m_tx[2] = c; m_tx[3] = d;
  endtask

  task automatic check_out(input string tag, input logic [15:0] a, b, c, d);
    check({tag, "_out0"}, 32'(sample_out0), 32'(a));
    check({tag, "_out1"}, 32'(sample_out1), 32'(b));
    check({tag, "_out2"}, 32'(sample_out2), 32'(c));
    check({tag, "_out3"}, 32'(sample_out3), 32'(d));
  endtask

  task automatic check_rx(input string tag, input logic [15:0] a, b, c, d);
    check({tag, "_rx0"}, 32'(m_rx[0]), 32'(a));
    check({tag, "_rx1"}, 32'(m_rx[1]), 32'(b));
    check({tag, "_rx2"}, 32'(m_rx[2]), 32'(c));
    check({tag, "_rx3"}, 32'(m_rx[3]), 32'(d));
  endtask

  initial begin
    logic so;
    sample_in0 = 16'hA5A5;
    sample_in1 = 16'h0001;
    sample_in2 = 16'h8000;
    sample_in3 = 16'h7FFF;
    set_tx(16'h0, 16'h0, 16'h0, 16'h0);
    for (int i = 0; i < 4; i++) m_rx[i] = 16'hDEAD;

    // Reset state
    repeat (5) @(negedge clk);
    check("rst_sdout", 32'(sdout), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_strobe", 32'(sample_strobe), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check_out("rst", 16'h0, 16'h0, 16'h0, 16'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Tail of a frame with lrck high: no lock yet, sdout stays 0
    send_range(120, 127);
    check("pre_locked", 32'(locked), 32'd0);
    check("pre_padbad", 32'(padbad), 32'd0);

    // Frame 1: lock, receive; transmit still zero
    set_tx(16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF);
    send_range(0, 127);
    check("f1_locked", 32'(locked), 32'd1);
    check("f1_strobes", 32'(strobes), 32'd1);
    check_out("f1", 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF);
    check_rx("f1", 16'h0, 16'h0, 16'h0, 16'h0);

    // Frame 2: transmit words now returned
    send_range(0, 127);
    check("f2_strobes", 32'(strobes), 32'd2);
    check_out("f2", 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF);
    check_rx("f2", 16'hA5A5, 16'h0001, 16'h8000, 16'h7FFF);

    // Pad bits all ones, data zero
    set_tx(16'h0, 16'h0, 16'h0, 16'h0);
    pad = 1'b1;
    send_range(0, 127);
    pad = 1'b0;
    check("pad_strobes", 32'(strobes), 32'd3);
    check_out("pad", 16'h0, 16'h0, 16'h0, 16'h0);
    check_rx("f3", 16'hA5A5, 16'h0001, 16'h8000, 16'h7FFF);

    // Misaligned frame start after cnt = 60
    set_tx(16'h9999, 16'h9999, 16'h9999, 16'h9999);
    send_range(0, 59);
    send_bit(1'b1, 1'b0, so);
    check("mis_ferr_before", 32'(errs), 32'd0);
    check("mis_partial_strobes", 32'(strobes), 32'd3);
    set_tx(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    send_range(0, 127);
    check("mis_ferr", 32'(errs), 32'd1);
    check("mis_strobes", 32'(strobes), 32'd4);
    check("mis_locked", 32'(locked), 32'd1);
    check_out("mis", 16'h1111, 16'h2222, 16'h3333, 16'h4444);

    // BICK stalled high after bit 47 (slot 1 LSB of 0x0001 on sdout)
    set_tx(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    send_range(0, 47);
    repeat (1000) @(negedge clk);
    check("stall_sdout", 32'(sdout), 32'd1);
    check("stall_strobes", 32'(strobes), 32'd4);
    check_out("stall", 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    send_range(48, 127);
    check("resume_strobes", 32'(strobes), 32'd5);
    check("resume_ferr", 32'(errs), 32'd1);
    check_out("resume", 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    check_rx("resume", 16'hA5A5, 16'h0001, 16'h8000, 16'h7FFF);

    // Reset mid-frame at cnt = 40
    set_tx(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    send_range(0, 40);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("mrst_locked", 32'(locked), 32'd0);
    check("mrst_sdout", 32'(sdout), 32'd0);
    check("mrst_strobe", 32'(sample_strobe), 32'd0);
    check_out("mrst", 16'h0, 16'h0, 16'h0, 16'h0);
    send_range(41, 127);
    check("mrst_nolock", 32'(locked), 32'd0);
    check("mrst_strobes", 32'(strobes), 32'd5);
    check("mrst_rx2", 32'(m_rx[2]), 32'd0);
    check("mrst_rx3", 32'(m_rx[3]), 32'd0);
    set_tx(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
    send_range(0, 127);
    check("relock", 32'(locked), 32'd1);
    check("relock_strobes", 32'(strobes), 32'd6);
    check("relock_ferr", 32'(errs), 32'd1);
    check_out("relock", 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
    check_rx("relock", 16'h0, 16'h0, 16'h0, 16'h0);

    check("strobe_back_to_back", 32'(dbl), 32'd0);
    check("pad_bits_zero", 32'(padbad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ak4619_codec_target.md
# ak4619_codec_target

Synthesizable target (codec-side) endpoint of the 4-slot TDM audio interface that our AK4619 driver masters. It receives BICK/LRCK/SDIN from an external master, deserializes the four DAC-direction slots, and serializes four ADC-direction samples back on SDOUT. It is used as an in-fabric codec model for board-less loopback and simulation, and for bridging to a second FPGA that runs the master driver.

## Interface
- `W`, 16: sample width in bits. Each slot is fixed at 32 BICK periods; the sample occupies bits 0..W-1 of the slot, MSB first.
- `clk`  in  1  system clock. Must run at least 12x the BICK frequency.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `bick`  in  1  bit clock from master (asynchronous to `clk`).
- `lrck`  in  1  frame clock from master: low for slots 0-1, high for slots 2-3.
- `sdin`  in  1  serial data from master (DAC direction).
- `sdout`  out  1  serial data to master (ADC direction).
- `sample_out0..3`  out  W each, signed  received slot 0..3 words.
- `sample_strobe`  out  1  one-`clk` pulse when `sample_out0..3` update.
- `sample_in0..3`  in  W each, signed  words to transmit in slot 0..3.
- `locked`  out  1  frame alignment acquired.
- `frame_err`  out  1  one-`clk` pulse on a misplaced frame start.

## Operation
- Input conditioning: `bick`, `lrck`, `sdin` each pass through a 2-flop synchronizer. One further register on synchronized `bick` gives `rise`/`fall` single-cycle flags. `lrck`/`sdin` are sampled on the `rise` cycle.
- Bit counter `cnt[6:0]` equals the index within the 128-bit frame of the bit just sampled. `slot = cnt[6:5]`, `pos = cnt[4:0]`.
- On `rise`: frame start is when sampled `lrck` is 0 and `lrck_prev` (sampled at the previous rise) is 1.
  - On frame start: `cnt <= 0`.
  - Otherwise: `cnt <= cnt + 1`, wrapping 127 -> 0.
  - `lrck_prev` updates on every rise.
- Lock and alignment:
  - At the first frame start, `locked` is set.
  - At a frame start while `locked` with old `cnt != 127`: pulse `frame_err`, realign, and stay locked.
  - The receive frame in progress is discarded, so no strobe is issued for it.
- Receive (only while `locked`):
  - On `rise` with `pos < W`: shift `sdin` into an LSB-first shift register, so the MSB arrives first.
  - At `pos == W-1`: copy the shift register to staging word `slot`.
  - At `cnt == 96+W-1`: load all four `sample_out` registers from staging simultaneously (slot 3 taken directly from the shifter) and pulse `sample_strobe`.
  - Bits with `pos >= W` are ignored.
- Transmit (only while `locked`):
  - On `fall`, compute `nxt = cnt + 1` (mod 128).
  - If `nxt == 0`, latch `sample_in0..3` into the tx buffer first.
  - Then `sdout <= (nxt[4:0] < W) ? tx[nxt[6:5]][W-1-nxt[4:0]] : 0`.
  - While unlocked, `sdout` is 0. The first valid transmitted frame is the one after the frame in which lock occurred.
- Reset values (synchronous, `rst_n == 0`):
  - `sdout`, `sample_out0..3`, `sample_strobe`, `frame_err`, `locked`, `cnt`: all 0.
  - `lrck_prev`, synchronizers, edge register, shifter, staging and tx buffers: all 0.
  - Reset mid-frame drops lock. Re-lock requires a fresh lrck high->low observed after reset.

## Timing
- A pin edge on `bick` produces the `rise`/`fall` flag on the 3rd `clk` edge after it.
- `sdout` changes on the `clk` edge after the `fall` flag, i.e. at most 4 `clk` cycles after BICK falls. This must be less than half a BICK period, which is why `clk` must be at least 12x BICK.
- `sample_strobe` is asserted in the same cycle `sample_out*` take new values. It fires once per 128-BICK frame when locked. It is never asserted in two consecutive cycles.
- `frame_err` and `sample_strobe` cannot coincide, because a realignment rise sets `cnt` to 0, not 111.
- Master timing convention: the master drives `lrck`/`sdin` on the BICK falling edge and samples `sdout` on the BICK rising edge. The block matches this by sampling on rise and driving on fall.
- BICK stalled: no counter advance, no strobe, outputs hold.

## Test plan
- Loopback: clk = 12x BICK, two frames with sdin slots 0x1234/0x8000/0x7FFF/0xFFFF -> `locked` = 1 after the first frame start; exactly one strobe per frame; `sample_out0..3` = 0x1234, 0x8000, 0x7FFF, 0xFFFF.
- Transmit: `sample_in0..3` = 0xA5A5/0x0001/0x8000/0x7FFF, decoded at the BICK rise by a model master -> frame 2 onward returns those values; bits 16-31 of every slot are 0; `sdout` is 0 before lock.
- Pad-bit immunity: sdin = 1 for all `pos >= 16`, sample data 0x0000 -> `sample_out*` = 0x0000.
- Misalignment: inject lrck high->low at `cnt` = 60 -> one `frame_err` pulse; no strobe for that frame; the next full frame strobes with correct data.
- Reset mid-frame: `rst_n` low for 2 cycles at `cnt` = 40 -> all outputs 0 next cycle and `locked` = 0; re-lock only at the next lrck fall.
- BICK stall: hold `bick` for 1000 `clk` cycles -> no strobe, `sdout` and `sample_out*` stable; clean resume afterward with no `frame_err`.
